// File: rtl/led_pkg.sv
// rtl/led_pkg.sv - shared types and defaults for the LED frame scheduler
package led_pkg;

   localparam int LED_DATA_W      = 128;
   localparam int LED_PERIOD_CYC  = 25000;
   localparam int LED_TIMEOUT_CYC = 4096;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LAUNCH,
      ST_WAIT_BUSY,
      ST_WAIT_DONE
   } led_sched_state_e;

endpackage

// File: rtl/led_rr_arb.sv
// rtl/led_rr_arb.sv - two-requester round-robin arbiter with one-hot grant
module led_rr_arb
   import led_pkg::*;
(
   input  logic       clk,
   input  logic       rstn,
   input  logic [1:0] req,
   input  logic       advance,
   output logic [1:0] grant
);

   // 1 when s1 won the most recent transfer; reset value lets s0 win the first tie
   logic last_s1;

   // a lone requester always wins; on a tie the source not granted last wins
   always_comb begin
      grant = req;
      if (req == 2'b11) begin
         grant = last_s1 ? 2'b01 : 2'b10;
      end
   end

   // remember the winner only when a transfer actually completes
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         last_s1 <= 1'b1;
      end else if (advance) begin
         last_s1 <= grant[1];
      end
   end

endmodule

// File: rtl/led_frame_sched.sv
// rtl/led_frame_sched.sv - periodic LED PHY frame launcher with one-entry pending buffer
module led_frame_sched
   import led_pkg::*;
#(
   parameter int DATA_W      = LED_DATA_W,
   parameter int PERIOD_CYC  = LED_PERIOD_CYC,
   parameter int TIMEOUT_CYC = LED_TIMEOUT_CYC
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              cfg_en,
   input  logic              s0_valid,
   output logic              s0_ready,
   input  logic [DATA_W-1:0] s0_data,
   input  logic              s1_valid,
   output logic              s1_ready,
   input  logic [DATA_W-1:0] s1_data,
   output logic              phy_enable,
   output logic [DATA_W-1:0] phy_data_in,
   input  logic              phy_busy,
   output logic              frame_done,
   output logic              overrun,
   output logic              timeout_err,
   input  logic              err_clr
);

   localparam int CW = (PERIOD_CYC > 1) ? $clog2(PERIOD_CYC) : 1;
   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(PERIOD_CYC - 1);
   localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYC - 1);

   led_sched_state_e  state;
   logic [CW-1:0]     period_cnt;
   logic [TW-1:0]     tmo_cnt;
   logic              pend_full;
   logic [DATA_W-1:0] pend_data;
   logic [DATA_W-1:0] active_data;
   logic [1:0]        grant;
   logic              tick;
   logic              launch;
   logic              xfer;
   logic [DATA_W-1:0] sel_data;

   assign s0_ready    = !pend_full;
   assign s1_ready    = !pend_full;
   assign tick        = cfg_en && (period_cnt == CNT_LAST);
   assign launch      = tick && (state == ST_IDLE);
   assign xfer        = !pend_full && (|grant);
   assign sel_data    = grant[1] ? s1_data : s0_data;
   assign phy_data_in = active_data;

   led_rr_arb u_arb (
      .clk     (clk),
      .rstn    (rstn),
      .req     ({s1_valid, s0_valid}),
      .advance (xfer),
      .grant   (grant)
   );

   // free-running refresh period counter, parked at zero while scheduling is off
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         period_cnt <= '0;
      end else if (!cfg_en || (period_cnt == CNT_LAST)) begin
         period_cnt <= '0;
      end else begin
         period_cnt <= period_cnt + 1'b1;
      end
   end

   // pending slot: drained by a launch, refilled only when it was empty this cycle
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         pend_full <= 1'b0;
         pend_data <= '0;
      end else if (launch && pend_full) begin
         pend_full <= 1'b0;
      end else if (xfer) begin
         pend_full <= 1'b1;
         pend_data <= sel_data;
      end
   end

   // launch and PHY handshake supervision with registered pulse outputs
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state       <= ST_IDLE;
         tmo_cnt     <= '0;
         active_data <= '0;
         phy_enable  <= 1'b0;
         frame_done  <= 1'b0;
         overrun     <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         phy_enable <= 1'b0;
         frame_done <= 1'b0;
         overrun    <= tick && (state != ST_IDLE);
         // a timeout below overrides a clear in the same cycle
         if (err_clr) begin
            timeout_err <= 1'b0;
         end
         case (state)
            ST_IDLE: begin
               if (tick) begin
                  state      <= ST_LAUNCH;
                  phy_enable <= 1'b1;
                  if (pend_full) begin
                     active_data <= pend_data;
                  end
               end
            end
            ST_LAUNCH: begin
               state   <= ST_WAIT_BUSY;
               tmo_cnt <= '0;
            end
            ST_WAIT_BUSY: begin
               if (phy_busy) begin
                  state   <= ST_WAIT_DONE;
                  tmo_cnt <= '0;
               end else if (tmo_cnt == TO_LAST) begin
                  timeout_err <= 1'b1;
                  state       <= ST_IDLE;
               end else begin
                  tmo_cnt <= tmo_cnt + 1'b1;
               end
            end
            ST_WAIT_DONE: begin
               if (!phy_busy) begin
                  frame_done <= 1'b1;
                  state      <= ST_IDLE;
               end else if (tmo_cnt == TO_LAST) begin
                  timeout_err <= 1'b1;
                  state       <= ST_IDLE;
               end else begin
                  tmo_cnt <= tmo_cnt + 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_led_frame_sched.sv
// tb/tb_led_frame_sched.sv - self-checking bench for led_frame_sched
module tb_led_frame_sched;
   import led_pkg::*;

   localparam int DW = 128;
   localparam int P  = 16;
   localparam int TO = 20;

   logic          clk = 1'b0;
   logic          rstn, cfg_en, err_clr;
   logic          s0_valid, s1_valid, s0_ready, s1_ready;
   logic [DW-1:0] s0_data, s1_data, phy_data_in;
   logic          phy_enable, phy_busy, frame_done, overrun, timeout_err;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   led_frame_sched #(.DATA_W(DW), .PERIOD_CYC(P), .TIMEOUT_CYC(TO)) dut (
      .clk         (clk),
      .rstn        (rstn),
      .cfg_en      (cfg_en),
      .s0_valid    (s0_valid),
      .s0_ready    (s0_ready),
      .s0_data     (s0_data),
      .s1_valid    (s1_valid),
      .s1_ready    (s1_ready),
      .s1_data     (s1_data),
      .phy_enable  (phy_enable),
      .phy_data_in (phy_data_in),
      .phy_busy    (phy_busy),
      .frame_done  (frame_done),
      .overrun     (overrun),
      .timeout_err (timeout_err),
      .err_clr     (err_clr)
   );

   // PHY model: holds busy for busy_len cycles after each enable (0 = never busy)
   int busy_len  = 5;
   int busy_left = 0;
   bit busy_rand = 0;

   // reference model: pending frames queue, launched frame, handshake progress
   int            m_cnt;
   logic [DW-1:0] pend_q[$];
   logic [DW-1:0] m_active;
   bit            m_in_hs, m_launch, m_got_busy, m_terr;
   int            m_wait;
   int            m_last;
   logic [5:0]    exp_flags;
   logic [DW-1:0] exp_data;

   function automatic logic [DW-1:0] rand_frame();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   function automatic void model_reset();
      m_cnt      = 0;
      pend_q.delete();
      m_active   = '0;
      m_in_hs    = 0;
      m_launch   = 0;
      m_got_busy = 0;
      m_terr     = 0;
      m_wait     = 0;
      m_last     = 1;
      exp_flags  = 6'b000011;
      exp_data   = '0;
   endfunction

   // predicts the outputs of the next cycle from this cycle's inputs
   function automatic void model_cycle();
      bit tick, ready, en, done, ovr, tmo;
      int src;
      tick  = cfg_en && (m_cnt == P - 1);
      ready = (pend_q.size() == 0);
      src   = -1;
      if (ready) begin
         if (s0_valid && s1_valid) src = (m_last == 0) ? 1 : 0;
         else if (s0_valid)        src = 0;
         else if (s1_valid)        src = 1;
      end
      en = 0; done = 0; ovr = 0; tmo = 0;
      if (!m_in_hs) begin
         if (tick) begin
            en = 1; m_in_hs = 1; m_launch = 1; m_got_busy = 0;
            if (pend_q.size() > 0) m_active = pend_q.pop_front();
         end
      end else begin
         ovr = tick;
         if (m_launch) begin
            m_launch = 0; m_wait = 0;
         end else if (!m_got_busy && phy_busy) begin
            m_got_busy = 1; m_wait = 0;
         end else if (m_got_busy && !phy_busy) begin
            done = 1; m_in_hs = 0;
         end else if (m_wait + 1 == TO) begin
            tmo = 1; m_in_hs = 0;
         end else begin
            m_wait++;
         end
      end
      if (src == 0) begin pend_q.push_back(s0_data); m_last = 0; end
      if (src == 1) begin pend_q.push_back(s1_data); m_last = 1; end
      if (tmo) m_terr = 1;
      else if (err_clr) m_terr = 0;
      m_cnt     = cfg_en ? (m_cnt + 1) % P : 0;
      exp_data  = m_active;
      exp_flags = {en, done, ovr, m_terr, pend_q.size() == 0, pend_q.size() == 0};
   endfunction

   // advance one cycle: model consumes current inputs, then PHY model reacts at the negedge
   task automatic step();
      if (!rstn) model_reset();
      else       model_cycle();
      @(negedge clk);
      if (!rstn) begin
         busy_left = 0;
      end else begin
         if (busy_left > 0) busy_left--;
         if (phy_enable) begin
            if (busy_rand) busy_len = $urandom_range(0, 12);
            if (busy_len > 0) busy_left = busy_len;
         end
      end
      phy_busy = (busy_left > 0);
   endtask

   task automatic test_reset();
      rstn = 1'b0; cfg_en = 1'b0; err_clr = 1'b0;
      s0_valid = 1'b0; s1_valid = 1'b0; s0_data = '0; s1_data = '0;
      for (int i = 0; i < 3; i++) begin
         step();
         n_checks++;
         if ({phy_enable, frame_done, overrun, timeout_err, s0_ready, s1_ready} !== 6'b000011
             || phy_data_in !== '0) begin
            n_fail++;
            $display("FAIL reset: flags %b data %h, expected flags 000011 data 0",
                     {phy_enable, frame_done, overrun, timeout_err, s0_ready, s1_ready}, phy_data_in);
         end
      end
      rstn = 1'b1;
   endtask

   task automatic test_refresh();
      int n_en = 0, n_done = 0;
      cfg_en = 1'b1; busy_len = 5;
      for (int i = 0; i < 48; i++) begin
         step();
         n_checks++;
         if ({phy_enable, frame_done, overrun, timeout_err, s0_ready, s1_ready} !== exp_flags
             || phy_data_in !== exp_data) begin
            n_fail++;
            $display("FAIL refresh cyc %0d: flags %b data %h, expected flags %b data %h",
                     i, {phy_enable, frame_done, overrun, timeout_err, s0_ready, s1_ready},
                     phy_data_in, exp_flags, exp_data);
         end
         if (phy_enable) n_en++;
         if (frame_done) n_done++;
      end
      n_checks++;
      if (n_en !== 3 || n_done !== 2) begin
         n_fail++;
         $display("FAIL refresh_count: enables %0d dones %0d, expected 3 and 2", n_en, n_done);
      end
   endtask

   task automatic test_single_frame();
      logic [DW-1:0] pat = {32{4'h5}};
      int n_en = 0;
      s0_valid = 1'b1; s0_data = pat;
      for (int i = 0; i < 49; i++) begin
         step();
         s0_valid = 1'b0; s0_data = rand_frame();
         n_checks++;
         if ({phy_enable, frame_done, overrun, timeout_err, s0_ready, s1_ready} !== exp_flags
             || phy_data_in !== exp_data) begin
            n_fail++;
            $display("FAIL single_frame cyc %0d: flags %b data %h, expected flags %b data %h",
                     i, {phy_enable, frame_done, overrun, timeout_err, s0_ready, s1_ready},
                     phy_data_in, exp_flags, exp_data);
         end
         if (phy_enable) begin
            n_en++;
            n_checks++;
            if (phy_data_in !== pat) begin
               n_fail++;
               $display("FAIL single_frame_data: got %h, expected %h", phy_data_in, pat);
            end
         end
      end
      n_checks++;
      if (n_en !== 3) begin
         n_fail++;
         $display("FAIL single_frame_count: enables %0d, expected 3", n_en);
      end
   endtask

   task automatic test_alternate();
      logic [DW-1:0] d0, d1, launched[$];
      d0 = rand_frame(); d1 = ~d0;
      s0_valid = 1'b1; s1_valid = 1'b1; s0_data = d0; s1_data = d1;
      for (int i = 0; i < 80; i++) begin
         step();
         n_checks++;
         if ({phy_enable, frame_done, overrun, timeout_err, s0_ready, s1_ready} !== exp_flags
             || phy_data_in !== exp_data) begin
            n_fail++;
            $display("FAIL alternate cyc %0d: flags %b data %h, expected flags %b data %h",
                     i, {phy_enable, frame_done, overrun, timeout_err, s0_ready, s1_ready},
                     phy_data_in, exp_flags, exp_data);
         end
         if (phy_enable) launched.push_back(phy_data_in);
      end
      s0_valid = 1'b0; s1_valid = 1'b0;
      n_checks++;
      if (launched.size() != 5) begin
         n_fail++;
         $display("FAIL alternate_count: launches %0d, expected 5", launched.size());
      end
      for (int k = 1; k < launched.size(); k++) begin
         n_checks++;
         if ((launched[k] !== d0 && launched[k] !== d1) || launched[k] === launched[k-1]) begin
            n_fail++;
            $display("FAIL alternate_order launch %0d: got %h after %h, expected the other source",
                     k, launched[k], launched[k-1]);
         end
      end
   endtask

   task automatic test_timeout();
      bit found = 0;
      busy_len = 0;
      for (int i = 0; i < 40 && !found; i++) begin
         step();
         n_checks++;
         if ({phy_enable, frame_done, overrun, timeout_err, s0_ready, s1_ready} !== exp_flags
             || phy_data_in !== exp_data) begin
            n_fail++;
            $display("FAIL timeout_wait cyc %0d: flags %b, expected %b", i,
                     {phy_enable, frame_done, overrun, timeout_err, s0_ready, s1_ready}, exp_flags);
         end
         if (phy_enable) found = 1;
      end
      n_checks++;
      if (!found) begin
         n_fail++;
         $display("FAIL timeout_launch: no enable within 40 cycles, expected one");
      end
      for (int i = 1; i <= TO + 1; i++) begin
         step();
         n_checks++;
         if ({phy_enable, frame_done, overrun, timeout_err, s0_ready, s1_ready} !== exp_flags) begin
            n_fail++;
            $display("FAIL timeout_run cyc %0d: flags %b, expected %b", i,
                     {phy_enable, frame_done, overrun, timeout_err, s0_ready, s1_ready}, exp_flags);
         end
      end
      n_checks++;
      if (timeout_err !== 1'b1) begin
         n_fail++;
         $display("FAIL timeout_set: timeout_err %b, expected 1", timeout_err);
      end
      err_clr = 1'b1;
      step();
      err_clr = 1'b0;
      n_checks++;
      if (timeout_err !== 1'b0) begin
         n_fail++;
         $display("FAIL timeout_clear: timeout_err %b, expected 0", timeout_err);
      end
      for (int i = 0; i < 20; i++) begin
         step();
         n_checks++;
         if ({phy_enable, frame_done, overrun, timeout_err, s0_ready, s1_ready} !== exp_flags
             || phy_data_in !== exp_data) begin
            n_fail++;
            $display("FAIL timeout_relaunch cyc %0d: flags %b, expected %b", i,
                     {phy_enable, frame_done, overrun, timeout_err, s0_ready, s1_ready}, exp_flags);
         end
      end
   endtask

   task automatic test_overrun();
      bit found = 0;
      int n_ovr = 0, n_en = 0;
      busy_len = 18;
      for (int i = 0; i < 40 && !found; i++) begin
         step();
         n_checks++;
         if ({phy_enable, frame_done, overrun, timeout_err, s0_ready, s1_ready} !== exp_flags) begin
            n_fail++;
            $display("FAIL overrun_wait cyc %0d: flags %b, expected %b", i,
                     {phy_enable, frame_done, overrun, timeout_err, s0_ready, s1_ready}, exp_flags);
         end
         if (phy_enable) found = 1;
      end
      n_checks++;
      if (!found) begin
         n_fail++;
         $display("FAIL overrun_launch: no enable within 40 cycles, expected one");
      end
      for (int i = 1; i <= 40; i++) begin
         step();
         n_checks++;
         if ({phy_enable, frame_done, overrun, timeout_err, s0_ready, s1_ready} !== exp_flags
             || phy_data_in !== exp_data) begin
            n_fail++;
            $display("FAIL overrun_run cyc %0d: flags %b, expected %b", i,
                     {phy_enable, frame_done, overrun, timeout_err, s0_ready, s1_ready}, exp_flags);
         end
         if (overrun) n_ovr++;
         if (phy_enable) n_en++;
      end
      n_checks++;
      if (n_ovr !== 1 || n_en !== 1) begin
         n_fail++;
         $display("FAIL overrun_count: overruns %0d enables %0d, expected 1 and 1", n_ovr, n_en);
      end
   endtask

   task automatic test_reset_mid();
      bit found = 0;
      int first_en = -1;
      busy_len = 5;
      for (int i = 0; i < 40 && !found; i++) begin
         step();
         if (phy_enable) found = 1;
      end
      n_checks++;
      if (!found) begin
         n_fail++;
         $display("FAIL reset_mid_launch: no enable within 40 cycles, expected one");
      end
      for (int i = 0; i < 3; i++) step();
      rstn = 1'b0;
      #1;
      n_checks++;
      if ({phy_enable, frame_done, overrun, timeout_err, s0_ready, s1_ready} !== 6'b000011
          || phy_data_in !== '0) begin
         n_fail++;
         $display("FAIL reset_async: flags %b data %h, expected flags 000011 data 0",
                  {phy_enable, frame_done, overrun, timeout_err, s0_ready, s1_ready}, phy_data_in);
      end
      step();
      step();
      rstn = 1'b1;
      for (int k = 1; k <= 40 && first_en < 0; k++) begin
         step();
         n_checks++;
         if ({phy_enable, frame_done, overrun, timeout_err, s0_ready, s1_ready} !== exp_flags
             || phy_data_in !== exp_data) begin
            n_fail++;
            $display("FAIL reset_mid_run cyc %0d: flags %b, expected %b", k,
                     {phy_enable, frame_done, overrun, timeout_err, s0_ready, s1_ready}, exp_flags);
         end
         if (phy_enable) first_en = k;
      end
      n_checks++;
      if (first_en !== P) begin
         n_fail++;
         $display("FAIL reset_mid_first_launch: at cycle %0d, expected %0d", first_en, P);
      end
   endtask

   task automatic test_random();
      busy_rand = 1;
      for (int i = 0; i < 600; i++) begin
         s0_valid = ($urandom_range(0, 3) == 0);
         s1_valid = ($urandom_range(0, 3) == 0);
         s0_data  = rand_frame();
         s1_data  = rand_frame();
         err_clr  = ($urandom_range(0, 19) == 0);
         if ($urandom_range(0, 99) == 0) cfg_en = ~cfg_en;
         step();
         n_checks++;
         if ({phy_enable, frame_done, overrun, timeout_err, s0_ready, s1_ready} !== exp_flags
             || phy_data_in !== exp_data) begin
            n_fail++;
            $display("FAIL random cyc %0d: flags %b data %h, expected flags %b data %h",
                     i, {phy_enable, frame_done, overrun, timeout_err, s0_ready, s1_ready},
                     phy_data_in, exp_flags, exp_data);
         end
      end
      s0_valid = 1'b0; s1_valid = 1'b0; err_clr = 1'b0; cfg_en = 1'b1;
   endtask

   initial begin
      phy_busy = 1'b0;
      model_reset();
      test_reset();
      test_refresh();
      test_single_frame();
      test_alternate();
      test_timeout();
      test_overrun();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1);
   end

endmodule
